rs_dec_outbuf: RTL

Output buffer and statistics stage placed directly downstream of the RS decoder. It captures every decoded word (`dec_vld`/`dec_data`) together with its ordered-set and decode-error sidebands into a small synchronous FIFO. It presents the words to the next stage over a valid/ready handshake, so back-pressure never stalls the decoder. It also keeps saturating counts of decode-error words and ordered-set words, plus a sticky overflow flag.

---
 rtl/rs_pkg.sv | 23 ++
 rtl/rs_dec_outbuf_if.sv | 30 +++
 rtl/rs_sync_fifo.sv | 73 +++++++
 rtl/rs_dec_outbuf.sv | 92 +++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// Shared definitions for the RS decoder datapath: word width, the buffered
// word layout and the saturating-counter helper.
package rs_pkg;

  localparam int unsigned DATA_WIDTH = 8;

  // One decoded word together with its sidebands, as stored in the buffer.
  typedef struct packed {
    logic                  isos;
    logic                  err;
    logic [DATA_WIDTH-1:0] data;
  } rs_word_t;

  // True when the low 'width' bits of 'value' are all ones, i.e. a counter
  // of that width has reached its saturation point.
  function automatic logic cnt_is_max(input logic [31:0] value,
                                      input int unsigned width);
    logic [31:0] mask;
    mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (value & mask) == mask;
  endfunction

endpackage

// File: rtl/rs_dec_outbuf_if.sv
// Decoder-side and downstream-side word streams of the RS output buffer.
// The master view belongs to the buffer, the slave view to its surroundings.
interface rs_dec_outbuf_if
  import rs_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = rs_pkg::DATA_WIDTH
);

  logic                  dec_vld;
  logic [DATA_WIDTH-1:0] dec_data;
  logic                  dec_isos;
  logic                  RDE_ERROR;

  logic                  out_vld;
  logic                  out_rdy;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_isos;
  logic                  out_err;

  modport master (
    input  dec_vld, dec_data, dec_isos, RDE_ERROR, out_rdy,
    output out_vld, out_data, out_isos, out_err
  );

  modport slave (
    output dec_vld, dec_data, dec_isos, RDE_ERROR, out_rdy,
    input  out_vld, out_data, out_isos, out_err
  );

endinterface

// File: rtl/rs_sync_fifo.sv
// Synchronous show-ahead FIFO with explicit occupancy tracking. A push into
// a full FIFO is accepted only when a pop frees the head in the same cycle;
// otherwise it is reported on 'drop' and the contents stay untouched.
module rs_sync_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push_req,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_rdy,
  output logic                     rd_vld,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     drop
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    level_q;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  // Push/pop qualification and head presentation.
  always_comb begin
    full    = (level_q == LW'(DEPTH));
    empty   = (level_q == '0);
    pop     = !empty && rd_rdy;
    push    = push_req && (!full || pop);
    drop    = push_req && full && !pop;
    rd_vld  = !empty;
    // Head is read from registered storage; masked to zero while empty so
    // no stale or uninitialised entry is ever visible after reset.
    rd_data = empty ? '0 : mem[rd_ptr];
    level   = level_q;
  end

  // Storage write; entries need no reset because 'level' gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/rs_dec_outbuf.sv
// Output buffer and statistics stage behind the RS decoder: queues decoded
// words with their sidebands, never stalls the decoder, and keeps saturating
// error / ordered-set counts plus a sticky overflow flag.
module rs_dec_outbuf
  import rs_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = rs_pkg::DATA_WIDTH,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   rs_ena,
  input  logic                   clr_stat,
  rs_dec_outbuf_if.master        bus,
  output logic [$clog2(DEPTH):0] level,
  output logic                   ovf,
  output logic [CNT_WIDTH-1:0]   err_cnt,
  output logic [CNT_WIDTH-1:0]   isos_cnt
);

  typedef struct packed {
    logic                  isos;
    logic                  err;
    logic [DATA_WIDTH-1:0] data;
  } word_t;

  word_t wr_word;
  word_t rd_word;
  logic  push_req;
  logic  drop;

  // Enable gating and packing of the incoming word.
  always_comb begin
    push_req     = rs_ena && bus.dec_vld;
    wr_word.isos = bus.dec_isos;
    wr_word.err  = bus.RDE_ERROR;
    wr_word.data = bus.dec_data;
  end

  rs_sync_fifo #(
    .WIDTH ($bits(word_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .push_req (push_req),
    .wr_data  (wr_word),
    .rd_rdy   (bus.out_rdy),
    .rd_vld   (bus.out_vld),
    .rd_data  (rd_word),
    .level    (level),
    .drop     (drop)
  );

  // Unpack the head entry onto the downstream stream.
  always_comb begin
    bus.out_data = rd_word.data;
    bus.out_isos = rd_word.isos;
    bus.out_err  = rd_word.err;
  end

  // Saturating statistics counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      err_cnt  <= '0;
      isos_cnt <= '0;
    end else if (clr_stat) begin
      err_cnt  <= '0;
      isos_cnt <= '0;
    end else begin
      if (push_req && bus.RDE_ERROR && !cnt_is_max(32'(err_cnt), CNT_WIDTH)) begin
        err_cnt <= err_cnt + CNT_WIDTH'(1);
      end
      if (push_req && bus.dec_isos && !cnt_is_max(32'(isos_cnt), CNT_WIDTH)) begin
        isos_cnt <= isos_cnt + CNT_WIDTH'(1);
      end
    end
  end

  // Sticky overflow; a drop in the clearing cycle keeps it set.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (clr_stat) begin
      ovf <= 1'b0;
    end
  end

endmodule
